// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates icache/dcache onto the single memory port and routes
// load completions back to the cache that owns each memory tag.

package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  bus_command_t       Icache2arb_command,
    input  logic [63:0]        Icache2arb_addr,
    input  bus_command_t       Dcache2arb_command,
    input  logic [63:0]        Dcache2arb_addr,
    input  logic [DATA_W-1:0]  Dcache2arb_data,
    input  logic [TAG_W-1:0]   mem2proc_response,
    input  logic [TAG_W-1:0]   mem2proc_tag,
    input  logic [DATA_W-1:0]  mem2proc_data,
    output bus_command_t       proc2mem_command,
    output logic [63:0]        proc2mem_addr,
    output logic [DATA_W-1:0]  proc2mem_data,
    output logic [TAG_W-1:0]   Arb2Icache_response,
    output logic [TAG_W-1:0]   Arb2Dcache_response,
    output logic [TAG_W-1:0]   Arb2Icache_tag,
    output logic [TAG_W-1:0]   Arb2Dcache_tag,
    output logic [DATA_W-1:0]  Arb2Icache_data,
    output logic [DATA_W-1:0]  Arb2Dcache_data,
    output logic               arb_err
);

    localparam int unsigned N_TAGS = 1 << TAG_W;
    localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);

    // Tag ownership table (entry 0 is never used), starvation counter, sticky error
    logic [N_TAGS-1:0] own_valid_q, own_valid_d;
    logic [N_TAGS-1:0] own_src_q,   own_src_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              arb_err_q,    arb_err_d;

    logic i_req, d_req, sel_i, sel_d;
    logic alloc, cpl_valid, cpl_hit;

    // Winner selection: dcache priority unless the icache has starved
    always_comb begin
        i_req     = (Icache2arb_command != BUS_NONE);
        d_req     = (Dcache2arb_command != BUS_NONE);
        sel_d     = d_req && !(i_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT)));
        sel_i     = i_req && !sel_d;
        alloc     = (mem2proc_response != '0) &&
                    ((sel_i && (Icache2arb_command == BUS_LOAD)) ||
                     (sel_d && (Dcache2arb_command == BUS_LOAD)));
        cpl_valid = (mem2proc_tag != '0);
        cpl_hit   = cpl_valid && own_valid_q[mem2proc_tag];
    end

    // Combinational request/response/completion routing, gated off during reset
    always_comb begin
        proc2mem_command    = BUS_NONE;
        proc2mem_addr       = '0;
        proc2mem_data       = '0;
        Arb2Icache_response = '0;
        Arb2Dcache_response = '0;
        Arb2Icache_tag      = '0;
        Arb2Dcache_tag      = '0;
        Arb2Icache_data     = '0;
        Arb2Dcache_data     = '0;
        if (reset) begin
            if (sel_d) begin
                proc2mem_command    = Dcache2arb_command;
                proc2mem_addr       = Dcache2arb_addr;
                proc2mem_data       = Dcache2arb_data;
                Arb2Dcache_response = mem2proc_response;
            end else if (sel_i) begin
                proc2mem_command    = Icache2arb_command;
                proc2mem_addr       = Icache2arb_addr;
                Arb2Icache_response = mem2proc_response;
            end
            if (cpl_hit) begin
                if (own_src_q[mem2proc_tag]) begin
                    Arb2Dcache_tag  = mem2proc_tag;
                    Arb2Dcache_data = mem2proc_data;
                end else begin
                    Arb2Icache_tag  = mem2proc_tag;
                    Arb2Icache_data = mem2proc_data;
                end
            end
        end
    end

    // Next state: retire completions, then allocate (allocation wins on a tag clash)
    always_comb begin
        own_valid_d  = own_valid_q;
        own_src_d    = own_src_q;
        arb_err_d    = arb_err_q;
        starve_cnt_d = '0;
        if (cpl_valid) begin
            if (cpl_hit) begin
                own_valid_d[mem2proc_tag] = 1'b0;
            end else begin
                arb_err_d = 1'b1;
            end
        end
        if (alloc) begin
            own_valid_d[mem2proc_response] = 1'b1;
            own_src_d[mem2proc_response]   = sel_d;
        end
        if (i_req && !sel_i) begin
            starve_cnt_d = (starve_cnt_q == CNT_W'(STARVE_LIMIT)) ? starve_cnt_q
                                                                  : starve_cnt_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            own_valid_q  <= '0;
            own_src_q    <= '0;
            starve_cnt_q <= '0;
            arb_err_q    <= 1'b0;
        end else begin
            own_valid_q  <= own_valid_d;
            own_src_q    <= own_src_d;
            starve_cnt_q <= starve_cnt_d;
            arb_err_q    <= arb_err_d;
        end
    end

    assign arb_err = arb_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: reference model feeds an expected-output queue
// each cycle; scenario tasks pop and compare, plus targeted direct checks.

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned TAG_W        = 4;
    localparam int unsigned DATA_W       = 64;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned OBS_W        = 2 + 64 + 64 + 4 * 4 + 64 * 2 + 1;

    typedef struct {
        string            nm;
        logic [OBS_W-1:0] v;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset;
    bus_command_t       Icache2arb_command;
    logic [63:0]        Icache2arb_addr;
    bus_command_t       Dcache2arb_command;
    logic [63:0]        Dcache2arb_addr;
    logic [DATA_W-1:0]  Dcache2arb_data;
    logic [TAG_W-1:0]   mem2proc_response;
    logic [TAG_W-1:0]   mem2proc_tag;
    logic [DATA_W-1:0]  mem2proc_data;
    bus_command_t       proc2mem_command;
    logic [63:0]        proc2mem_addr;
    logic [DATA_W-1:0]  proc2mem_data;
    logic [TAG_W-1:0]   Arb2Icache_response;
    logic [TAG_W-1:0]   Arb2Dcache_response;
    logic [TAG_W-1:0]   Arb2Icache_tag;
    logic [TAG_W-1:0]   Arb2Dcache_tag;
    logic [DATA_W-1:0]  Arb2Icache_data;
    logic [DATA_W-1:0]  Arb2Dcache_data;
    logic               arb_err;

    logic [OBS_W-1:0]   obs;
    exp_t               exp_q[$];
    int                 n_cmp  = 0;
    int                 n_fail = 0;

    // Reference model state
    logic               m_v [16];
    logic               m_s [16];
    int unsigned        m_starve;
    logic               m_err;

    mem_arbiter #(
        .TAG_W(TAG_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .Icache2arb_command(Icache2arb_command), .Icache2arb_addr(Icache2arb_addr),
        .Dcache2arb_command(Dcache2arb_command), .Dcache2arb_addr(Dcache2arb_addr),
        .Dcache2arb_data(Dcache2arb_data),
        .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
        .mem2proc_data(mem2proc_data),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .Arb2Icache_response(Arb2Icache_response), .Arb2Dcache_response(Arb2Dcache_response),
        .Arb2Icache_tag(Arb2Icache_tag), .Arb2Dcache_tag(Arb2Dcache_tag),
        .Arb2Icache_data(Arb2Icache_data), .Arb2Dcache_data(Arb2Dcache_data),
        .arb_err(arb_err)
    );

    always #5 clock = ~clock;

    assign obs = {2'(proc2mem_command), proc2mem_addr, proc2mem_data,
                  Arb2Icache_response, Arb2Dcache_response,
                  Arb2Icache_tag, Arb2Dcache_tag,
                  Arb2Icache_data, Arb2Dcache_data, arb_err};

    // 0 = nobody, 1 = icache, 2 = dcache
    function automatic int winner();
        logic i_req, d_req;
        i_req = (Icache2arb_command != BUS_NONE);
        d_req = (Dcache2arb_command != BUS_NONE);
        if (i_req && d_req) return (m_starve == STARVE_LIMIT) ? 1 : 2;
        if (i_req) return 1;
        if (d_req) return 2;
        return 0;
    endfunction

    function automatic logic [OBS_W-1:0] model_out();
        logic [1:0]  cmd;
        logic [63:0] addr, pd, id, dd;
        logic [3:0]  ir, dr, it, dt;
        int          w;
        cmd = 2'b0; addr = '0; pd = '0; id = '0; dd = '0;
        ir = '0; dr = '0; it = '0; dt = '0;
        if (reset) begin
            w = winner();
            if (w == 1) begin
                cmd = 2'(Icache2arb_command); addr = Icache2arb_addr; ir = mem2proc_response;
            end else if (w == 2) begin
                cmd = 2'(Dcache2arb_command); addr = Dcache2arb_addr;
                pd = Dcache2arb_data; dr = mem2proc_response;
            end
            if (mem2proc_tag != 4'h0 && m_v[mem2proc_tag]) begin
                if (m_s[mem2proc_tag]) begin dt = mem2proc_tag; dd = mem2proc_data; end
                else begin it = mem2proc_tag; id = mem2proc_data; end
            end
        end
        return {cmd, addr, pd, ir, dr, it, dt, id, dd, reset ? m_err : 1'b0};
    endfunction

    // Apply the effect of the rising edge that just passed, using the inputs held across it
    task automatic model_commit();
        int w;
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin m_v[i] = 1'b0; m_s[i] = 1'b0; end
            m_starve = 0;
            m_err    = 1'b0;
            return;
        end
        w = winner();
        if (mem2proc_tag != 4'h0) begin
            if (m_v[mem2proc_tag]) m_v[mem2proc_tag] = 1'b0;
            else m_err = 1'b1;
        end
        if (mem2proc_response != 4'h0 &&
            ((w == 1 && Icache2arb_command == BUS_LOAD) ||
             (w == 2 && Dcache2arb_command == BUS_LOAD))) begin
            m_v[mem2proc_response] = 1'b1;
            m_s[mem2proc_response] = (w == 2);
        end
        if (Icache2arb_command != BUS_NONE && w != 1)
            m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
        else
            m_starve = 0;
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its expected outputs
    task automatic cycle(input string nm, input bus_command_t ic, input logic [63:0] ia,
                         input bus_command_t dc, input logic [63:0] da, input logic [63:0] dd,
                         input logic [3:0] rs, input logic [3:0] tg, input logic [63:0] md,
                         input logic rn);
        exp_t e;
        @(negedge clock);
        model_commit();
        reset              = rn;
        Icache2arb_command = ic;
        Icache2arb_addr    = ia;
        Dcache2arb_command = dc;
        Dcache2arb_addr    = da;
        Dcache2arb_data    = dd;
        mem2proc_response  = rs;
        mem2proc_tag       = tg;
        mem2proc_data      = md;
        #2;
        e.nm = nm;
        e.v  = model_out();
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            cycle("reset_hold", BUS_LOAD, 64'h100, BUS_LOAD, 64'h200, 64'h55, 4'h3, 4'h0, 64'h0, 1'b0);
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        end
        n_cmp++;
        if (proc2mem_command !== BUS_NONE || Arb2Icache_response !== 4'h0 || Arb2Dcache_response !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cmd=%0d iresp=%0d dresp=%0d exp 0/0/0",
                     proc2mem_command, Arb2Icache_response, Arb2Dcache_response);
        end
        cycle("reset_release", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h0, 64'h0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
    endtask

    task automatic test_icache_load();
        exp_t e;
        cycle("iload_accept", BUS_LOAD, 64'h1230, BUS_NONE, 64'h0, 64'h0, 4'h3, 4'h0, 64'h0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        n_cmp++;
        if (Arb2Icache_response !== 4'h3 || proc2mem_addr !== 64'h1230) begin
            n_fail++;
            $display("FAIL iload_resp: got resp=%0d addr=%h exp 3/1230", Arb2Icache_response, proc2mem_addr);
        end
        cycle("iload_wait", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h0, 64'h0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        cycle("iload_complete", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h3, 64'hDEAD, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        n_cmp++;
        if (Arb2Icache_tag !== 4'h3 || Arb2Icache_data !== 64'hDEAD ||
            Arb2Dcache_tag !== 4'h0 || Arb2Dcache_data !== 64'h0) begin
            n_fail++;
            $display("FAIL iload_route: got itag=%0d idata=%h dtag=%0d ddata=%h exp 3/dead/0/0",
                     Arb2Icache_tag, Arb2Icache_data, Arb2Dcache_tag, Arb2Dcache_data);
        end
    endtask

    task automatic test_both_load();
        exp_t e;
        cycle("both_accept", BUS_LOAD, 64'hA000, BUS_LOAD, 64'hB000, 64'h0, 4'h5, 4'h0, 64'h0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        n_cmp++;
        if (Arb2Dcache_response !== 4'h5 || Arb2Icache_response !== 4'h0) begin
            n_fail++;
            $display("FAIL both_winner: got dresp=%0d iresp=%0d exp 5/0", Arb2Dcache_response, Arb2Icache_response);
        end
        cycle("both_iretry", BUS_LOAD, 64'hA000, BUS_NONE, 64'h0, 64'h0, 4'h6, 4'h0, 64'h0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        cycle("both_cpl5", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h5, 64'hB5B5, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        n_cmp++;
        if (Arb2Dcache_tag !== 4'h5 || Arb2Dcache_data !== 64'hB5B5 || Arb2Icache_tag !== 4'h0) begin
            n_fail++;
            $display("FAIL both_route5: got dtag=%0d ddata=%h itag=%0d exp 5/b5b5/0",
                     Arb2Dcache_tag, Arb2Dcache_data, Arb2Icache_tag);
        end
        cycle("both_cpl6", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h6, 64'hA6A6, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
    endtask

    task automatic test_starvation();
        exp_t e;
        int   first_win;
        first_win = 0;
        for (int c = 1; c <= 8 && first_win == 0; c++) begin
            cycle("starve", BUS_LOAD, 64'h4000, BUS_STORE, 64'h5000 + 64'(c), 64'(c), 4'hF, 4'h0, 64'h0, 1'b1);
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
            if (Arb2Icache_response != 4'h0) first_win = c;
        end
        n_cmp++;
        if (first_win != STARVE_LIMIT + 1) begin
            n_fail++;
            $display("FAIL starve_first_win: got cycle=%0d exp cycle=%0d", first_win, STARVE_LIMIT + 1);
        end
        cycle("starve_cleared", BUS_LOAD, 64'h4100, BUS_STORE, 64'h6000, 64'h66, 4'h1, 4'h0, 64'h0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        n_cmp++;
        if (Arb2Icache_response !== 4'h0 || proc2mem_command !== BUS_STORE) begin
            n_fail++;
            $display("FAIL starve_reset_cnt: got iresp=%0d cmd=%0d exp 0/2", Arb2Icache_response, proc2mem_command);
        end
        cycle("starve_cplF", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'hF, 64'hF00D, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
    endtask

    task automatic test_same_tag();
        exp_t e;
        cycle("same_ialloc", BUS_LOAD, 64'h7000, BUS_NONE, 64'h0, 64'h0, 4'h7, 4'h0, 64'h0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        cycle("same_clash", BUS_NONE, 64'h0, BUS_LOAD, 64'hC000, 64'h0, 4'h7, 4'h7, 64'h77, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        n_cmp++;
        if (Arb2Icache_tag !== 4'h7 || Arb2Icache_data !== 64'h77 || Arb2Dcache_response !== 4'h7) begin
            n_fail++;
            $display("FAIL same_clash_route: got itag=%0d idata=%h dresp=%0d exp 7/77/7",
                     Arb2Icache_tag, Arb2Icache_data, Arb2Dcache_response);
        end
        cycle("same_dcpl", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h7, 64'h88, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        n_cmp++;
        if (Arb2Dcache_tag !== 4'h7 || Arb2Dcache_data !== 64'h88 || Arb2Icache_tag !== 4'h0 || arb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL same_dcpl_route: got dtag=%0d ddata=%h itag=%0d err=%b exp 7/88/0/0",
                     Arb2Dcache_tag, Arb2Dcache_data, Arb2Icache_tag, arb_err);
        end
    endtask

    task automatic test_store_err();
        exp_t e;
        cycle("store_accept", BUS_NONE, 64'h0, BUS_STORE, 64'h8000, 64'h1234, 4'h2, 4'h0, 64'h0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        cycle("store_bogus_cpl", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h2, 64'h9999, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        for (int c = 0; c < 3; c++) begin
            cycle("store_err_sticky", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h0, 64'h0, 1'b1);
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        end
        n_cmp++;
        if (arb_err !== 1'b1) begin n_fail++; $display("FAIL store_err_set: got=%b exp=1", arb_err); end
        cycle("store_err_reset", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h0, 64'h0, 1'b0);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        n_cmp++;
        if (arb_err !== 1'b0) begin n_fail++; $display("FAIL store_err_clear: got=%b exp=0", arb_err); end
    endtask

    task automatic test_reset_inflight();
        exp_t e;
        cycle("inflight_alloc", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h0, 64'h0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        cycle("inflight_alloc", BUS_LOAD, 64'h9000, BUS_NONE, 64'h0, 64'h0, 4'h4, 4'h0, 64'h0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        cycle("inflight_rst", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h9, 64'h0, 1'b0);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        cycle("inflight_release", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h0, 64'h0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        n_cmp++;
        if (arb_err !== 1'b0) begin n_fail++; $display("FAIL inflight_no_err_in_reset: got=%b exp=0", arb_err); end
        cycle("inflight_cpl", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h4, 64'h4444, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        n_cmp++;
        if (Arb2Icache_tag !== 4'h0 || Arb2Icache_data !== 64'h0) begin
            n_fail++;
            $display("FAIL inflight_dropped: got itag=%0d idata=%h exp 0/0", Arb2Icache_tag, Arb2Icache_data);
        end
        cycle("inflight_err", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h0, 64'h0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        n_cmp++;
        if (arb_err !== 1'b1) begin n_fail++; $display("FAIL inflight_err_set: got=%b exp=1", arb_err); end
    endtask

    task automatic test_random();
        exp_t         e;
        bus_command_t ic, dc;
        logic [3:0]   tg;
        cycle("rand_reset", BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'h0, 4'h0, 64'h0, 1'b0);
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.nm, obs, e.v); end
        for (int c = 0; c < 300; c++) begin
            ic = ($urandom_range(0, 1) != 0) ? BUS_LOAD : BUS_NONE;
            dc = bus_command_t'(2'($urandom_range(0, 2)));
            tg = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            cycle("random", ic, {$urandom, $urandom}, dc, {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom_range(0, 15)), tg, {$urandom, $urandom}, 1'b1);
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s[%0d]: got=%h exp=%h", e.nm, c, obs, e.v); end
        end
    endtask

    initial begin
        reset              = 1'b0;
        Icache2arb_command = BUS_NONE;
        Icache2arb_addr    = '0;
        Dcache2arb_command = BUS_NONE;
        Dcache2arb_addr    = '0;
        Dcache2arb_data    = '0;
        mem2proc_response  = '0;
        mem2proc_tag       = '0;
        mem2proc_data      = '0;
        for (int i = 0; i < 16; i++) begin m_v[i] = 1'b0; m_s[i] = 1'b0; end
        m_starve = 0;
        m_err    = 1'b0;

        test_reset();
        test_icache_load();
        test_both_load();
        test_starvation();
        test_same_tag();
        test_store_err();
        test_reset_inflight();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
